// File: rtl/ram_arbiter_pkg.sv
// Shared constants for ram_arbiter: access-size codes, FSM state codes and
// RAM latency bounds, plus the size-to-last-byte-index helper.
package ram_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_RDW  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_ACK  = 3'd4;

  localparam int unsigned RAM_LAT_MIN = 1;
  localparam int unsigned RAM_LAT_MAX = 3;

  // Index of the final byte of an access; size 11 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SIZE_B:  last_idx = 2'd0;
      SIZE_H:  last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_rd_pipe.sv
// Read-return tracker: one stage per RAM latency cycle, carrying a valid bit,
// the byte index and a last-byte flag for every issued read address.
module ram_arbiter_rd_pipe #(
  parameter int unsigned LAT = 1
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       i_vld,
  input  logic [1:0] i_idx,
  input  logic       i_last,
  output logic       o_stb,
  output logic [1:0] o_idx,
  output logic       o_last
);

  logic [LAT-1:0]      r_vld;
  logic [LAT-1:0]      r_last;
  logic [LAT-1:0][1:0] r_idx;

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_last <= '0;
      r_idx  <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_last[0] <= i_last;
      r_idx[0]  <= i_idx;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_last[k] <= r_last[k-1];
        r_idx[k]  <= r_idx[k-1];
      end
    end
  end

  assign o_stb  = r_vld[LAT-1];
  assign o_idx  = r_idx[LAT-1];
  assign o_last = r_last[LAT-1] & r_vld[LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master (IF read-only, MEM read/write) arbiter onto a byte-wide RAM port,
// serialising accesses little-endian. Define RAM_ARB_RR_EN for round-robin.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ack_o,
  output logic [31:0]       mem_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  logic [2:0]        r_state;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last_idx;
  logic              r_sel_mem;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_mem_rdata;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_wdata;

  logic              w_any_req;
  logic              w_grant_mem;
  logic              w_grant_we;
  logic [1:0]        w_cnt_nxt;
  logic              w_stb;
  logic [1:0]        w_pipe_idx;
  logic              w_pipe_last;
  logic [31:0]       w_merged;

  assign w_any_req = mem_req_i | if_req_i;

`ifdef RAM_ARB_RR_EN
  logic r_last_mem;

  // Contention goes to whichever master was not served last.
  assign w_grant_mem = mem_req_i & (~if_req_i | ~r_last_mem);

  always_ff @(posedge dclk or posedge rst) begin
    if (rst)
      r_last_mem <= 1'b0;
    else if (r_state == ST_IDLE && w_any_req)
      r_last_mem <= w_grant_mem;
  end
`else
  assign w_grant_mem = mem_req_i;
`endif

  assign w_grant_we = w_grant_mem & mem_we_i;
  assign w_cnt_nxt  = r_cnt + 2'd1;

  ram_arbiter_rd_pipe #(
    .LAT (RAM_LAT)
  ) u_rd_pipe (
    .dclk   (dclk),
    .rst    (rst),
    .i_vld  (r_ram_en & ~r_ram_we),
    .i_idx  (r_cnt),
    .i_last (r_cnt == r_last_idx),
    .o_stb  (w_stb),
    .o_idx  (w_pipe_idx),
    .o_last (w_pipe_last)
  );

  // Returning byte merged in place so the final byte lands in the same edge as ack.
  always_comb begin
    w_merged = r_asm;
    w_merged[{w_pipe_idx, 3'b000} +: 8] = ram_rdata_i;
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_idx  <= '0;
      r_sel_mem   <= 1'b0;
      r_wdata     <= '0;
      r_asm       <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      if (w_stb)
        r_asm <= w_merged;

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_sel_mem   <= w_grant_mem;
            r_last_idx  <= w_grant_mem ? last_idx(mem_size_i) : 2'd3;
            r_wdata     <= mem_wdata_i;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_ram_en    <= 1'b1;
            r_ram_we    <= w_grant_we;
            r_ram_addr  <= w_grant_mem ? mem_addr_i : if_addr_i;
            r_ram_wdata <= w_grant_we ? mem_wdata_i[7:0] : 8'h00;
            r_state     <= w_grant_we ? ST_WR : ST_RD;
          end
        end

        ST_RD: begin
          if (r_cnt == r_last_idx) begin
            r_ram_en <= 1'b0;
            r_state  <= ST_RDW;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_ram_addr <= r_ram_addr + ADDR_W'(1);
          end
        end

        ST_RDW: begin
          if (w_pipe_last) begin
            if (r_sel_mem) begin
              r_mem_ack   <= 1'b1;
              r_mem_rdata <= w_merged;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_merged;
            end
            r_state <= ST_ACK;
          end
        end

        ST_WR: begin
          if (r_cnt == r_last_idx) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 8'h00;
            r_mem_ack   <= 1'b1;
            r_state     <= ST_ACK;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_ram_addr  <= r_ram_addr + ADDR_W'(1);
            r_ram_wdata <= r_wdata[{w_cnt_nxt, 3'b000} +: 8];
          end
        end

        ST_ACK:  r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_en_o    = r_ram_en;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wdata_o = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RAM_LAT 1 and 3), each with a byte RAM
// model; expectations come from a golden byte array and latency arithmetic.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int NI = 2;

  logic        dclk;
  logic        rst;
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        if_ack    [NI];
  logic [31:0] if_rdata  [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [1:0]  mem_size  [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic        mem_ack   [NI];
  logic [31:0] mem_rdata [NI];
  logic        ram_en    [NI];
  logic        ram_we    [NI];
  logic [31:0] ram_addr  [NI];
  logic [7:0]  ram_wdata [NI];
  logic [7:0]  ram_rdata [NI];

  logic [7:0]  ram  [NI][4096];
  logic [7:0]  gold [NI][4096];
  logic [11:0] pa   [NI][3];
  bit          inited = 1'b0;
  int          cyc = 0;
  int          n_if_ack  [NI];
  int          n_mem_ack [NI];

  int checks   = 0;
  int failures = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_arbiter #(
      .ADDR_W  (32),
      .RAM_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .dclk        (dclk),
      .rst         (rst),
      .if_req_i    (if_req[g]),
      .if_addr_i   (if_addr[g]),
      .if_ack_o    (if_ack[g]),
      .if_rdata_o  (if_rdata[g]),
      .mem_req_i   (mem_req[g]),
      .mem_we_i    (mem_we[g]),
      .mem_size_i  (mem_size[g]),
      .mem_addr_i  (mem_addr[g]),
      .mem_wdata_i (mem_wdata[g]),
      .mem_ack_o   (mem_ack[g]),
      .mem_rdata_o (mem_rdata[g]),
      .ram_en_o    (ram_en[g]),
      .ram_we_o    (ram_we[g]),
      .ram_addr_o  (ram_addr[g]),
      .ram_wdata_o (ram_wdata[g]),
      .ram_rdata_i (ram_rdata[g])
    );
    assign ram_rdata[g] = ram[g][pa[g][((g == 0) ? 1 : 3) - 1]];
  end

  // Byte RAM: content from a fixed formula, then writes; reads delayed by RAM_LAT.
  always @(posedge dclk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      if (if_ack[g] === 1'b1)  n_if_ack[g]  <= n_if_ack[g] + 1;
      if (mem_ack[g] === 1'b1) n_mem_ack[g] <= n_mem_ack[g] + 1;
      pa[g][0] <= ram_addr[g][11:0];
      pa[g][1] <= pa[g][0];
      pa[g][2] <= pa[g][1];
    end
    if (!inited) begin
      for (int g = 0; g < NI; g++)
        for (int k = 0; k < 4096; k++)
          ram[g][k] <= 8'(k * 7 + g * 13 + 3);
      inited <= 1'b1;
    end else begin
      for (int g = 0; g < NI; g++)
        if (ram_en[g] === 1'b1 && ram_we[g] === 1'b1)
          ram[g][ram_addr[g][11:0]] <= ram_wdata[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns the cycle number at which the ack is seen, or -1.
  task automatic wait_ack(input int g, input bit is_mem, input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      if ((is_mem ? mem_ack[g] : if_ack[g]) === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge dclk);
    end
  endtask

  task automatic txn(input int g, input bit is_mem, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int n, lat, e, at, own0, oth0;
    logic [31:0] expv;
    n    = !is_mem ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    lat  = (is_mem && we) ? n : n + lat_of(g);
    expv = '0;
    for (int i = 0; i < n; i++) expv[8*i +: 8] = gold[g][12'(addr + 32'(i))];
    @(negedge dclk);
    own0 = is_mem ? n_mem_ack[g] : n_if_ack[g];
    oth0 = is_mem ? n_if_ack[g] : n_mem_ack[g];
    if (is_mem) begin
      mem_req[g] = 1'b1; mem_we[g] = we; mem_size[g] = size;
      mem_addr[g] = addr; mem_wdata[g] = wdata;
    end else begin
      if_req[g] = 1'b1; if_addr[g] = addr;
    end
    @(negedge dclk);
    e = cyc;
    wait_ack(g, is_mem, 40, at);
    chk({tag, "_lat"}, 32'(at < 0 ? 999 : at - e), 32'(lat));
    if (!(is_mem && we))
      chk({tag, "_rdata"}, is_mem ? mem_rdata[g] : if_rdata[g], expv);
    if (is_mem) begin mem_req[g] = 1'b0; mem_we[g] = 1'b0; end
    else if_req[g] = 1'b0;
    if (is_mem && we) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_wbyte"}, 32'(ram[g][12'(addr + 32'(i))]), 32'(wdata[8*i +: 8]));
        gold[g][12'(addr + 32'(i))] = wdata[8*i +: 8];
      end
      chk({tag, "_untouched"}, 32'(ram[g][12'(addr + 32'(n))]), 32'(gold[g][12'(addr + 32'(n))]));
    end
    @(negedge dclk);
    chk({tag, "_pulse"}, 32'(is_mem ? mem_ack[g] : if_ack[g]), 32'd0);
    chk({tag, "_one_ack"}, 32'(is_mem ? n_mem_ack[g] : n_if_ack[g]), 32'(own0 + 1));
    chk({tag, "_other_quiet"}, 32'(is_mem ? n_if_ack[g] : n_mem_ack[g]), 32'(oth0));
    if (!(is_mem && we))
      chk({tag, "_hold"}, is_mem ? mem_rdata[g] : if_rdata[g], expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, e, a1, snap;
    int seq [4];
    int exp_seq [4];
    int na;
    bit rm, ri;
    logic [31:0] expv;

    for (int g = 0; g < NI; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0; mem_req[g] = 1'b0; mem_we[g] = 1'b0;
      mem_size[g] = '0; mem_addr[g] = '0; mem_wdata[g] = '0;
      n_if_ack[g] = 0; n_mem_ack[g] = 0;
      for (int k = 0; k < 4096; k++) gold[g][k] = 8'(k * 7 + g * 13 + 3);
    end
    rst = 1'b1;
    repeat (3) @(negedge dclk);
    for (int g = 0; g < NI; g++) begin
      chk("rst_ram_en", 32'(ram_en[g]), 32'd0);
      chk("rst_ram_addr", ram_addr[g], 32'd0);
      chk("rst_acks", 32'({if_ack[g], mem_ack[g], ram_we[g]}), 32'd0);
      chk("rst_rdata", if_rdata[g] | mem_rdata[g] | 32'(ram_wdata[g]), 32'd0);
    end
    rst = 1'b0;

    // Half write leaves the third byte alone; then preset 0x100 and read it back.
    txn(0, 1'b1, 1'b1, 2'b01, 32'h200, 32'hAABBCCDD, "half_wr");
    for (int g = 0; g < NI; g++)
      txn(g, 1'b1, 1'b1, 2'b10, 32'h100, 32'h44332211, "preset_wr");
    txn(0, 1'b0, 1'b0, 2'b10, 32'h100, '0, "if_word_rd");
    chk("if_word_value", if_rdata[0], 32'h44332211);
    txn(0, 1'b1, 1'b0, 2'b00, 32'h103, '0, "mem_byte_rd");
    chk("mem_byte_value", mem_rdata[0], 32'h00000044);
    txn(1, 1'b1, 1'b0, 2'b10, 32'h100, '0, "lat3_word_rd");
    txn(1, 1'b1, 1'b0, 2'b00, 32'h101, '0, "lat3_byte_rd");
    txn(1, 1'b1, 1'b1, 2'b11, 32'h120, 32'hDEADBEEF, "lat3_sz11_wr");

    for (int g = 0; g < NI; g++) begin
      for (int t = 0; t < 24; t++) begin
        bit          im;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        im = ($urandom % 3) != 0;
        w  = im && ($urandom % 2 == 1);
        sz = 2'($urandom % 4);
        a  = 32'h300 + 32'($urandom_range(0, 60));
        txn(g, im, w, sz, a, $urandom, "rand");
      end
    end

    // Request held through ACK and the following IDLE edge: exactly one more transfer.
    @(negedge dclk);
    snap = n_mem_ack[0];
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_size[0] = 2'b00; mem_addr[0] = 32'h103;
    @(negedge dclk);
    e = cyc;
    wait_ack(0, 1'b1, 20, at);
    chk("hold_first_lat", 32'(at < 0 ? 999 : at - e), 32'd2);
    a1 = cyc;
    @(negedge dclk);
    @(negedge dclk);
    wait_ack(0, 1'b1, 20, at);
    chk("hold_second_gap", 32'(at < 0 ? 999 : at - a1), 32'd4);
    mem_req[0] = 1'b0;
    repeat (12) @(negedge dclk);
    chk("hold_ack_count", 32'(n_mem_ack[0]), 32'(snap + 2));

    // Reset after two bytes of an IF word read have returned.
    snap = n_if_ack[0];
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    repeat (4) @(negedge dclk);
    #1 rst = 1'b1;
    if_req[0] = 1'b0;
    #1;
    chk("arst_outs", 32'({ram_en[0], ram_we[0], if_ack[0], mem_ack[0]}), 32'd0);
    chk("arst_addr", ram_addr[0] | 32'(ram_wdata[0]), 32'd0);
    chk("arst_rdata", if_rdata[0] | mem_rdata[0], 32'd0);
    @(negedge dclk);
    rst = 1'b0;
    repeat (10) @(negedge dclk);
    chk("arst_no_ack", 32'(n_if_ack[0]), 32'(snap));
    txn(0, 1'b0, 1'b0, 2'b10, 32'h100, '0, "arst_reread");
    chk("arst_reread_value", if_rdata[0], 32'h44332211);

    // Simultaneous requests: MEM first, IF granted two cycles after the MEM ack.
    @(negedge dclk);
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_size[0] = 2'b10; mem_addr[0] = 32'h100;
    if_req[0] = 1'b1; if_addr[0] = 32'h104;
    @(negedge dclk);
    e = cyc;
    wait_ack(0, 1'b1, 20, at);
    chk("cont_mem_lat", 32'(at < 0 ? 999 : at - e), 32'd5);
    chk("cont_mem_data", mem_rdata[0], 32'h44332211);
    chk("cont_if_waiting", 32'(if_ack[0]), 32'd0);
    mem_req[0] = 1'b0;
    a1 = cyc;
    wait_ack(0, 1'b0, 20, at);
    chk("cont_if_lat", 32'(at < 0 ? 999 : at - a1), 32'd7);
    expv = '0;
    for (int i = 0; i < 4; i++) expv[8*i +: 8] = gold[0][12'(32'h104 + 32'(i))];
    chk("cont_if_data", if_rdata[0], expv);
    if_req[0] = 1'b0;
    repeat (3) @(negedge dclk);

    // Repeated contention: each master re-requests right after its own ack.
`ifdef RAM_ARB_RR_EN
    exp_seq = '{1, 0, 1, 0};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    na = 0; rm = 1'b0; ri = 1'b0;
    seq = '{-1, -1, -1, -1};
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_size[0] = 2'b00; mem_addr[0] = 32'h103;
    if_req[0] = 1'b1; if_addr[0] = 32'h100;
    for (int k = 0; k < 100 && na < 4; k++) begin
      @(negedge dclk);
      if (rm) begin mem_req[0] = 1'b1; rm = 1'b0; end
      if (ri) begin if_req[0] = 1'b1; ri = 1'b0; end
      if (mem_ack[0] === 1'b1 && na < 4) begin
        seq[na] = 1; na++; mem_req[0] = 1'b0; rm = 1'b1;
      end
      if (if_ack[0] === 1'b1 && na < 4) begin
        seq[na] = 0; na++; if_req[0] = 1'b0; ri = 1'b1;
      end
    end
    mem_req[0] = 1'b0; if_req[0] = 1'b0;
    repeat (12) @(negedge dclk);
    chk("rr_grants_seen", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sits directly downstream of the MEM stage and the IF stage, between them and the single byte-wide RAM port.
- Accepts word, half-word or byte requests from two masters: IF (read-only) and MEM (read/write).
- Arbitrates between them and serialises each granted request into little-endian byte accesses on the RAM port.
- Returns assembled read data with a one-cycle ack pulse.
- MEM keeps its own sign-extension logic; this block only returns raw zero-extended bytes.

Parameters:
- ADDR_W, 32: address width of requester and RAM ports.
- RAM_LAT, 1: RAM read latency in dclk cycles. Legal values 1..3. Data for the address presented in cycle k is sampled at the end of cycle k+RAM_LAT.

Ports:
- dclk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  IF read request, level
- if_addr_i  in  ADDR_W  IF byte address; access size is always word
- if_ack_o  out  1  one-cycle pulse: IF request done
- if_rdata_o  out  32  IF read data, valid while if_ack_o is high
- mem_req_i  in  1  MEM request, level
- mem_we_i  in  1  1 = write, 0 = read
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr_i  in  ADDR_W  MEM byte address
- mem_wdata_i  in  32  store data; low bytes are used for byte/half accesses
- mem_ack_o  out  1  one-cycle pulse: MEM request done
- mem_rdata_o  out  32  zero-extended read data, valid while mem_ack_o is high
- ram_en_o  out  1  RAM access enable
- ram_we_o  out  1  RAM write enable (qualified by ram_en_o)
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wdata_o  out  8  RAM write byte
- ram_rdata_i  in  8  RAM read byte

Behaviour:
- Reset (async, any state): all outputs 0, FSM to IDLE, byte counter and in-flight read pipe cleared. Partially read data is discarded and no ack is issued for the aborted transfer.
- FSM states:
  - IDLE: evaluate requests.
  - RD: issue read addresses.
  - RDW: drain read latency.
  - WR: issue write bytes.
  - ACK: one cycle with ack high.
- Arbitration: in IDLE, if mem_req_i is high, MEM is granted; else if if_req_i is high, IF is granted. Simultaneous requests resolve to MEM (older instruction).
- No preemption: a grant holds until its ack.
- At the grant edge E, the block latches address, size, we and wdata. Requester inputs are ignored until ack.
- Byte count N: 1, 2 or 4.
  - Byte i uses address addr+i, modulo 2^ADDR_W; wrap-around is not checked.
  - Byte i maps to data bits [8i+7:8i].
- Read timing:
  - Byte i address is presented in the cycle after edge E+i, with ram_en_o=1 and ram_we_o=0.
  - Byte i is captured at edge E+1+i+RAM_LAT.
  - ram_en_o drops after the last address is issued.
  - The ack and the final rdata (including the last byte) are registered at edge E+N+RAM_LAT.
  - Examples: word with RAM_LAT=1 acks at E+5; byte acks at E+2.
  - Unused upper bytes of mem_rdata_o are 0.
- Write timing:
  - Byte i is presented in the cycle after edge E+i, with ram_en_o=1 and ram_we_o=1.
  - The ack is registered at edge E+N, and ram_en_o/ram_we_o drop at the same edge.
- ACK state:
  - Exactly one ack pulse is asserted; rdata holds its value until the next ack.
  - Requests are ignored during ACK, and the FSM returns to IDLE at the next edge.
  - The requester must drop req in the ack cycle; if req is still high in IDLE, it is taken as a new request.
- The requester not granted simply waits with req held high; no ack is issued to it.
- ram_wdata_o is don't-care during reads and is driven to 0.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register (reset value: IF) gives priority to the master not granted last when both request in IDLE.
- Undefined: fixed MEM priority; the register is absent.

Decomposition:
- Shared header (macro.vh): constants for size encodings (SIZE_B/H/W), FSM state encodings, and RAM_LAT bounds.
- Sub-module ram_rd_pipe: a RAM_LAT-deep shift register carrying a valid bit and byte index per issued read. Its output strobe writes ram_rdata_i into the assembly register and flags the last byte.

Test Plan:
1. RAM[0x100..0x103]=11,22,33,44; IF word read 0x100 with RAM_LAT=1 -> if_ack_o at E+5, if_rdata_o=0x44332211, mem_ack_o stays 0.
2. MEM half write 0x200, data 0xAABBCCDD -> RAM[0x200]=DD, RAM[0x201]=CC, RAM[0x202] unchanged, mem_ack_o at E+2.
3. MEM byte read 0x103 -> mem_rdata_o=0x00000044, ack at E+2; repeat with RAM_LAT=3 and a word read -> ack at E+7.
4. IF and MEM requests rise on the same edge -> MEM served first; IF ack arrives after the MEM ack plus ACK/IDLE cycles; with RAM_ARB_RR_EN and repeated contention, grants alternate.
5. rst pulsed after two bytes of a word read -> all outputs 0 immediately, no ack; a following IF read of 0x100 returns 0x44332211 correctly.
6. Requester holds req one cycle past ack -> no request is sampled during ACK; exactly one new transaction starts from IDLE.
